znc_chain_adder: RTL and testbench
==================================

ZNC_CHAIN_ADDER -- requirements
Module: znc_chain_adder

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 8, maximum number of 16-bit words in one chained operation.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, operand word pair present.
REQ-005 SHALL have port in_ready, output, 1, block accepts the operand word pair this cycle.
REQ-006 SHALL have ports a_in and b_in, input, 16 each, operand words, least significant word first.
REQ-007 SHALL have port sub, input, 1, 1 = A-B, 0 = A+B; sampled only on the first word.
REQ-008 SHALL have ports first and last, input, 1 each, chain delimiters; both may be high for a single-word operation.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), sum_out (output, 16) and out_last (output, 1) forming the result word stream.
REQ-010 SHALL have ports flag_z, flag_n, flag_c and flag_v (output, 1 each) holding the chain's zero, negative, carry and overflow flags.
REQ-011 SHALL have ports flags_valid (output, 1), flags describe a completed chain, and err (output, 1), one-cycle protocol-error pulse.

Function
REQ-012 SHALL treat a word as accepted when in_valid and in_ready are both high; in_ready = !out_valid or out_ready.
REQ-013 SHALL register sum_out, out_last and out_valid on acceptance, giving one-cycle latency; out_valid clears when out_ready is high and no new word is accepted.
REQ-014 SHALL hold sum_out and out_last stable while out_valid is high and out_ready is low.
REQ-015 SHALL run a two-state FSM: IDLE (expects first word) and CHAIN (mid-operation).
REQ-016 SHALL, on a first word, latch sub, use carry-in = sub, clear the word counter and the zero accumulator, and drop flags_valid.
REQ-017 SHALL, on later words, use carry-in = the stored carry and the latched sub.
REQ-018 SHALL compute sum = a_in + (sub ? ~b_in : b_in) + carry-in, modulo 2^16.
REQ-019 SHALL compute carry-out = (a15 & b15') | ((a15 | b15') & ~s15), where b15' is bit 15 of the effective B and s15 is bit 15 of the sum.
REQ-020 SHALL store carry-out for the next word.
REQ-021 SHALL accumulate zero as the AND of (sum == 0) over all words in the chain.
REQ-022 SHALL, on acceptance of a last word, register flag_z = accumulated zero, flag_n = s15, flag_c = carry-out and flag_v = (a15 == b15') & (s15 != a15), and set flags_valid; all are updated together with the last word's output register.
REQ-023 SHALL define flag_c on subtraction as "no borrow" (1 when A >= B, unsigned).
REQ-024 SHALL hold the flags and flags_valid until the next first word is accepted or reset.
REQ-025 SHALL transition IDLE->CHAIN on an accepted first word without last, CHAIN->IDLE on an accepted last word, and IDLE->IDLE on a word with first and last both set.
REQ-026 SHALL treat first asserted in CHAIN as an abort-and-restart: pulse err, discard the old carry and zero accumulator, and process the word as a new first word; flags from the aborted chain are not written.
REQ-027 SHALL treat a word without first accepted in IDLE as a first word (carry-in = sub) and pulse err.
REQ-028 SHALL, when the MAX_WORDS-th word of a chain is accepted without last, process it as last (out_last = 1, flags written, return to IDLE) and pulse err.
REQ-029 SHALL ignore a_in, b_in, sub, first and last whenever the word is not accepted.

Reset
REQ-030 SHALL, when reset is high at a clock edge, force IDLE, out_valid = 0, sum_out = 0, out_last = 0, all flags = 0, flags_valid = 0, err = 0, stored carry = 0 and counter = 0.
REQ-031 SHALL let reset override any simultaneous acceptance, and SHALL discard a chain interrupted by reset mid-operation without writing its flags.

Verification
REQ-032 SHALL be verified with: add 0x7FFF + 0x0001, first = last = 1 -> sum 0x8000, N=1, V=1, C=0, Z=0, flags_valid high one cycle after acceptance.
REQ-033 SHALL be verified with: two-word add 0x0001_FFFF + 0x0000_0001 -> words 0x0000 then 0x0002, Z=0, C=0, N=0, V=0.
REQ-034 SHALL be verified with: subtract 0x0005 - 0x0005, single word -> sum 0x0000, Z=1, C=1, N=0, V=0; then 0x0003 - 0x0005 -> 0xFFFE, C=0, N=1.
REQ-035 SHALL be verified with: out_ready held low 3 cycles while in_valid is high -> in_ready low, sum_out constant, no word lost or duplicated after release.
REQ-036 SHALL be verified with: first reasserted on the 2nd word of a chain -> err pulses 1 cycle, new chain's carry-in = sub, and the earlier flags remain unchanged until the new last word.
REQ-037 SHALL be verified with: reset asserted mid-chain, then a clean single-word chain -> all outputs 0 after reset and correct results with no carry leakage.

Source files
------------

// File: rtl/znc_chain_adder.sv
// Chained multi-word adder/subtractor with ready/valid handshake on both sides.
// Processes one 16-bit word pair per accepted beat, least significant word first.
module znc_chain_adder #(
  parameter int MAX_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        sub,
  input  logic        first,
  input  logic        last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum_out,
  output logic        out_last,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_c,
  output logic        flag_v,
  output logic        flags_valid,
  output logic        err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {IDLE, CHAIN} state_t;

  state_t          state;
  logic            carry_r;
  logic            sub_r;
  logic            zero_r;
  logic [CW-1:0]   count_r;

  logic            accept;
  logic            is_first;
  logic            sub_eff;
  logic            cin;
  logic [15:0]     b_eff;
  logic [15:0]     sum;
  logic            carry_out;
  logic [CW-1:0]   count;
  logic            force_last;
  logic            eff_last;
  logic            zero_new;
  logic            proto_err;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A word that starts a chain (explicitly, or implicitly from IDLE) drops any stale carry/accumulator state.
  always_comb begin
    is_first   = (state == IDLE) || first;
    sub_eff    = is_first ? sub : sub_r;
    cin        = is_first ? sub : carry_r;
    b_eff      = sub_eff ? ~b_in : b_in;
    sum        = a_in + b_eff + {15'd0, cin};
    carry_out  = (a_in[15] & b_eff[15]) | ((a_in[15] | b_eff[15]) & ~sum[15]);
    count      = is_first ? '0 : count_r;
    force_last = (count == CW'(MAX_WORDS - 1)) && !last;
    eff_last   = last || force_last;
    zero_new   = (is_first ? 1'b1 : zero_r) & (sum == 16'd0);
    proto_err  = ((state == CHAIN) && first) || ((state == IDLE) && !first) || force_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      carry_r     <= 1'b0;
      sub_r       <= 1'b0;
      zero_r      <= 1'b0;
      count_r     <= '0;
      out_valid   <= 1'b0;
      sum_out     <= 16'd0;
      out_last    <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      flag_v      <= 1'b0;
      flags_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        out_valid <= 1'b1;
        sum_out   <= sum;
        out_last  <= eff_last;
        carry_r   <= carry_out;
        sub_r     <= sub_eff;
        zero_r    <= zero_new;
        err       <= proto_err;
        if (eff_last) begin
          state       <= IDLE;
          count_r     <= '0;
          flag_z      <= zero_new;
          flag_n      <= sum[15];
          flag_c      <= carry_out;
          flag_v      <= (a_in[15] == b_eff[15]) && (sum[15] != a_in[15]);
          flags_valid <= 1'b1;
        end else begin
          state   <= CHAIN;
          count_r <= count + CW'(1);
          if (is_first) flags_valid <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_znc_chain_adder.sv
// Directed bench for znc_chain_adder: result words go through a scoreboard queue,
// flags and err are compared against hand-derived constants.
module tb_znc_chain_adder;

  localparam int MAXW = 4;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        sub;
  logic        first;
  logic        last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum_out;
  logic        out_last;
  logic        flag_z;
  logic        flag_n;
  logic        flag_c;
  logic        flag_v;
  logic        flags_valid;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  bit          m_in_chain;
  bit          m_carry;
  bit          m_sub;
  int          m_cnt;

  znc_chain_adder #(.MAX_WORDS(MAXW)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a_in(a_in),
    .b_in(b_in),
    .sub(sub),
    .first(first),
    .last(last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_out(sum_out),
    .out_last(out_last),
    .flag_z(flag_z),
    .flag_n(flag_n),
    .flag_c(flag_c),
    .flag_v(flag_v),
    .flags_valid(flags_valid),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic z, input logic n, input logic c, input logic v);
    checkOutput({tag, "_fv"}, flags_valid, 1);
    checkOutput({tag, "_z"}, flag_z, z);
    checkOutput({tag, "_n"}, flag_n, n);
    checkOutput({tag, "_c"}, flag_c, c);
    checkOutput({tag, "_v"}, flag_v, v);
  endtask

  // Reference behaviour of one accepted word: full-width add gives the carry directly.
  task automatic modelAccept();
    logic        is_first;
    logic        s;
    logic        cin;
    logic [15:0] be;
    logic [16:0] full;
    logic        eff_last;
    int          cnt;
    is_first = !m_in_chain || first;
    s        = is_first ? sub : m_sub;
    cin      = is_first ? sub : m_carry;
    be       = s ? ~b_in : b_in;
    full     = {1'b0, a_in} + {1'b0, be} + {16'd0, cin};
    cnt      = is_first ? 0 : m_cnt;
    eff_last = last || (cnt == MAXW - 1);
    exp_q.push_back({eff_last, full[15:0]});
    m_in_chain = !eff_last;
    m_carry    = full[16];
    m_sub      = s;
    m_cnt      = cnt + 1;
  endtask

  // One clock: pop/compare a delivered word, model an accepted word, advance to next negedge.
  task automatic tick(output bit accepted);
    logic [16:0] e;
    #1;
    if (out_valid && out_ready) begin
      checkOutput("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("word_sum", sum_out, e[15:0]);
        checkOutput("word_last", out_last, e[16]);
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) modelAccept();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s,
                               input logic f, input logic l);
    bit acc;
    a_in     = a;
    b_in     = b;
    sub      = s;
    first    = f;
    last     = l;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    checkOutput("accept_timeout", acc, 1);
    in_valid = 1'b0;
    a_in     = 16'hDEAD;
    b_in     = 16'hBEEF;
  endtask

  task automatic drain();
    bit acc;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid); i++) tick(acc);
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_in      = 16'd0;
    b_in      = 16'd0;
    sub       = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    out_ready = 1'b1;
    m_in_chain = 0;
    m_carry    = 0;
    m_sub      = 0;
    m_cnt      = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sum", sum_out, 0);
    checkOutput("rst_flags", {flag_z, flag_n, flag_c, flag_v, flags_valid, err}, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    $display("[TB] single-word add overflow");
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
    checkOutput("ovf_err", err, 0);
    checkFlags("ovf", 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    $display("[TB] two-word add with carry");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    checkOutput("two_fv_drop", flags_valid, 0);
    applyStimulus(16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("two_err", err, 0);
    checkFlags("two", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("[TB] subtraction");
    applyStimulus(16'h0005, 16'h0005, 1'b1, 1'b1, 1'b1);
    checkFlags("sub_eq", 1'b1, 1'b0, 1'b1, 1'b0);
    drain();
    applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
    checkFlags("sub_lt", 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    $display("[TB] output backpressure");
    out_ready = 1'b0;
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b1, 1'b0);
    a_in     = 16'h0001;
    b_in     = 16'h0002;
    first    = 1'b0;
    last     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      checkOutput("bp_no_accept", acc, 0);
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_sum_hold", sum_out, 16'h2345);
    end
    out_ready = 1'b1;
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] abort and restart");
    applyStimulus(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b1);
    drain();
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_hold_n", flag_n, 1);
    applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b1, 1'b0);
    checkOutput("abort_err", err, 1);
    checkOutput("abort_fv", flags_valid, 0);
    checkOutput("abort_hold_n2", flag_n, 1);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("abort_err_pulse", err, 0);
    checkFlags("abort", 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    $display("[TB] missing first in idle");
    applyStimulus(16'h0002, 16'h0001, 1'b1, 1'b0, 1'b1);
    checkOutput("nofirst_err", err, 1);
    checkFlags("nofirst", 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    $display("[TB] chain length limit");
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MAXW - 2; i++) begin
      applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("max_err_early", err, 0);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkOutput("max_err", err, 1);
    checkFlags("max", 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    $display("[TB] reset mid-chain");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_in_chain = 0;
    m_carry    = 0;
    m_cnt      = 0;
    checkOutput("mid_rst_out", {out_valid, out_last, sum_out}, 0);
    checkOutput("mid_rst_flags", {flag_z, flag_n, flag_c, flag_v, flags_valid, err}, 0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b1, 1'b1);
    checkOutput("post_rst_err", err, 0);
    checkFlags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_sum", sum_out, 16'h0002);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
